// File: rtl/ula_seq_if.sv
// Operation request / result bundle between a controller and ula_seq.
// Latency: none, wiring only.
// Backpressure: controller must hold off new requests while busy is high.
interface ula_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] s;
    logic             ovf;
    logic             busy;
    logic             done;

    // Controller side drives requests and observes results
    modport master (
        output start, op, e0, e1,
        input  s, ovf, busy, done
    );

    // ULA side consumes requests and produces results
    modport slave (
        input  start, op, e0, e1,
        output s, ovf, busy, done
    );
endinterface

// File: rtl/ula_seq.sv
// Sequential add/sub/mul/and unit with start/busy/done handshake (macro ULA_FAST_MUL_EN: 1-cycle multiply).
// Latency: add/sub/and 1 cycle after accept; mul WIDTH cycles (1 with ULA_FAST_MUL_EN).
// Backpressure: start is ignored while busy=1; no queueing, one operation in flight.
module ula_seq #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    ula_seq_if.slave     bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
`ifndef ULA_FAST_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd2;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [1:0]       state_q, state_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] s_q,     s_d;
    logic             ovf_q,   ovf_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;

    logic [WIDTH-1:0] exec_s;
    logic             exec_ovf;
    logic [WIDTH:0]   add_sum;

`ifdef ULA_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod;
`else
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] acc_nxt;

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        acc_nxt = acc_q;
        if (mplier_q[0]) begin
            acc_nxt = acc_q + mcand_q;
        end
    end
`endif

    // Single-cycle result for operations completed in EXEC
    always_comb begin
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        exec_s   = a_q & b_q;
        exec_ovf = 1'b0;
`ifdef ULA_FAST_MUL_EN
        prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif
        case (op_q)
            OP_ADD: begin
                exec_s   = add_sum[WIDTH-1:0];
                exec_ovf = add_sum[WIDTH];
            end
            OP_SUB: begin
                exec_s   = a_q - b_q;
                exec_ovf = (a_q < b_q);
            end
`ifdef ULA_FAST_MUL_EN
            OP_MUL: begin
                exec_s   = prod[WIDTH-1:0];
                exec_ovf = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                exec_s   = a_q & b_q;
                exec_ovf = 1'b0;
            end
        endcase
    end

    // Control FSM and next-state for all registers
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        s_d      = s_q;
        ovf_d    = ovf_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
`ifndef ULA_FAST_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.e0;
                    b_d     = bus.e1;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
`ifndef ULA_FAST_MUL_EN
                    if (bus.op == OP_MUL) begin
                        state_d  = ST_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.e0};
                        mplier_d = bus.e1;
                        cnt_d    = '0;
                    end
`endif
                end
            end
            ST_EXEC: begin
                s_d     = exec_s;
                ovf_d   = exec_ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
`ifndef ULA_FAST_MUL_EN
            ST_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Only the finished product reaches s, never a partial sum
                if (cnt_q == LAST_ITER) begin
                    s_d     = acc_nxt[WIDTH-1:0];
                    ovf_d   = |acc_nxt[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; synchronous reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_q      <= '0;
            ovf_q    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
`ifndef ULA_FAST_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s_q      <= s_d;
            ovf_q    <= ovf_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
`ifndef ULA_FAST_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.s    = s_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, clocked successor of the team's combinational add/multiply ULA.
- Operand width is set by a parameter.
- Supports four operations selected by a 2-bit opcode: add, subtract, AND and multiply.
- Multiply uses an iterative shift-add datapath.
- A start/busy/done handshake lets a controller or testbench issue one operation at a time and sample a registered result with flags.

Parameters:
WIDTH, 16, operand and result width in bits (must be at least 2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only while busy=0
op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 and
e0  input  WIDTH  operand A, unsigned
e1  input  WIDTH  operand B, unsigned
s  output  WIDTH  registered result
ovf  output  1  registered flag: add carry-out, sub borrow, mul high-half nonzero, and = 0
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when s/ovf are updated

Behaviour:
- Reset: the clock and reset are one clock; reset is synchronous and active-high.
  - rst=1 at a rising edge forces s=0, ovf=0, busy=0, done=0 and state=IDLE.
  - Reset has priority over everything and aborts any operation in progress, including a multiply.
- Operand capture: e0, e1 and op are latched at the accepting edge. Later changes on these inputs do not affect the result.
- States: IDLE, EXEC, MUL.
- IDLE:
  - start=1 at edge k latches the operands and opcode and sets busy=1.
  - Next state is MUL if op=10, otherwise EXEC.
  - start=0 keeps the block in IDLE.
- EXEC (one cycle):
  - At edge k+1, s and ovf are loaded with the result, done=1, busy=0, and the state returns to IDLE.
- Results for add/sub/and (arithmetic is modulo 2^WIDTH):
  - add: s = low WIDTH bits of e0+e1; ovf = carry-out.
  - sub: s = (e0-e1) mod 2^WIDTH; ovf = 1 iff e0<e1.
  - and: s = e0&e1; ovf = 0.
- MUL:
  - A 2*WIDTH accumulator is cleared at entry, with the multiplicand and multiplier held in shift registers.
  - Each cycle, the accumulator adds the shifted multiplicand when the current multiplier LSB is 1, then both shift.
  - After exactly WIDTH iterations, at edge k+WIDTH:
    - s = low WIDTH bits of the product;
    - ovf = 1 iff the high WIDTH bits are nonzero;
    - done=1, busy=0, state returns to IDLE.
- Latency from the accepting edge to done: add/sub/and = 1 cycle; mul = WIDTH cycles.
- done is high for exactly one cycle. s and ovf hold their value until the next completion or reset.
- start while busy=1 is ignored: no queueing, and the latched operands are unchanged.
- start held high across completion:
  - On the edge where done is set, the block is not yet in IDLE, so start is not accepted.
  - A new operation is accepted at the following edge if start is still 1, giving back-to-back throughput of one operation per (latency+1) cycles.
- Zero operands: mul with e1=0 still takes WIDTH cycles, producing s=0 and ovf=0.
- The output s never shows intermediate accumulator values.

Optional Feature:
ULA_FAST_MUL_EN
- Defined: op=10 is routed to EXEC and computed with a single-cycle combinational full-width product. Latency is 1 cycle, the MUL state and shift registers are not built, and s/ovf rules are unchanged.
- Not defined: iterative shift-add multiply with WIDTH-cycle latency, as described above.

Test Plan:
- Reset: apply rst=1 for 2 cycles -> s=0, ovf=0, busy=0, done=0. Then start=1, op=00, e0=3, e1=2 -> done one cycle later with s=5, ovf=0.
- Add/sub wrap: e0=16'hFFFF, e1=1, op=00 -> s=0, ovf=1. e0=2, e1=3, op=01 -> s=16'hFFFF, ovf=1.
- Multiply:
  - e0=3, e1=2, op=10 -> busy high for 16 cycles, done at edge k+16, s=6, ovf=0.
  - e0=16'h0100, e1=16'h0100 -> s=0, ovf=1.
  - With ULA_FAST_MUL_EN defined, the same cases complete at edge k+1.
- Busy protection: during a mul (e0=3, e1=3), pulse start with op=00, e0=7, e1=7 and change the e0/e1 inputs -> result s=9, ovf=0, exactly one done pulse, add not executed.
- Reset mid-operation: assert rst at cycle 5 of a mul -> next edge busy=0, s=0, no done pulse. A subsequent op=11 with e0=16'h00F0, e1=16'h0FF0 -> s=16'h00F0, ovf=0.
- Held start: start tied high with op=00, e0=1, e1=1 -> done pulses every 2 cycles, s=2 each time.
